// File: rtl/fft_writeback_unit.sv
// FFT write-back unit: buffers the write-address pair of every sample pair issued to the
// butterfly unit, rejoins it with the butterfly results in issue order, and drives the
// in-place RAM write port. It also tracks pairs and stages so the sequencer can see when
// a stage and the whole transform are complete.
module fft_writeback_unit #(
    parameter int unsigned N             = 32,
    parameter int unsigned word_size     = 16,
    parameter int unsigned fifo_depth    = 8,
    parameter int unsigned address_width = $clog2(N),
    parameter int unsigned stage_width   = $clog2($clog2(N)),
    parameter int unsigned pair_id_width = $clog2(N / 2)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_start,
    input  logic                     i_addr_valid,
    input  logic [address_width-1:0] i_wr_address1,
    input  logic [address_width-1:0] i_wr_address2,
    output logic                     o_addr_ready,
    input  logic                     i_BPU_valid,
    input  logic [2*word_size-1:0]   i_BPU_result1,
    input  logic [2*word_size-1:0]   i_BPU_result2,
    output logic                     o_RAM_we,
    output logic [address_width-1:0] o_RAM_wr_address1,
    output logic [address_width-1:0] o_RAM_wr_address2,
    output logic [2*word_size-1:0]   o_RAM_wr_data1,
    output logic [2*word_size-1:0]   o_RAM_wr_data2,
    output logic [stage_width-1:0]   o_stage,
    output logic                     o_stage_done,
    output logic                     o_fft_done,
    output logic                     o_error
);

    localparam int unsigned PtrW  = $clog2(fifo_depth);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned DataW = 2 * word_size;

    localparam logic [CntW-1:0]          DepthCnt    = CntW'(fifo_depth);
    localparam logic [pair_id_width-1:0] LastPairId  = pair_id_width'(N / 2 - 1);
    localparam logic [stage_width-1:0]   LastStageId = stage_width'($clog2(N) - 1);

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    state_e r_state;
    state_e w_state_next;

    // Address-pair FIFO storage and bookkeeping
    logic [address_width-1:0] r_fifo_addr1 [fifo_depth];
    logic [address_width-1:0] r_fifo_addr2 [fifo_depth];
    logic [PtrW-1:0]          r_wr_ptr;
    logic [PtrW-1:0]          r_rd_ptr;
    logic [CntW-1:0]          r_count;

    // Write-port and progress registers
    logic                     r_ram_we;
    logic [address_width-1:0] r_ram_addr1;
    logic [address_width-1:0] r_ram_addr2;
    logic [DataW-1:0]         r_ram_data1;
    logic [DataW-1:0]         r_ram_data2;
    logic [pair_id_width-1:0] r_pair_count;
    logic [stage_width-1:0]   r_stage;
    logic                     r_stage_done;
    logic                     r_fft_done;
    logic                     r_error;

    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_last_pair;
    logic w_last_stage;
    logic w_err;

    // Handshake decode; a pop in the same cycle frees a slot, so a push at full is still taken
    always_comb begin
        w_ready      = (r_state == StRun) && (r_count < DepthCnt);
        w_pop        = i_BPU_valid && (r_state == StRun) && (r_count != '0);
        w_push       = i_addr_valid && (w_ready || w_pop);
        w_last_pair  = w_pop && (r_pair_count == LastPairId);
        w_last_stage = w_last_pair && (r_stage == LastStageId);
        w_err        = (i_addr_valid && !w_push) || (i_BPU_valid && !w_pop);
    end

    // Next-state logic; i_start wins over completion of the final stage
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = StRun;
                end
            end
            StRun: begin
                if (i_start) begin
                    w_state_next = StRun;
                end else if (w_last_stage) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FIFO storage; a push coinciding with i_start is discarded by the pointer flush
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr1[r_wr_ptr] <= i_wr_address1;
            r_fifo_addr2[r_wr_ptr] <= i_wr_address2;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally modulo fifo_depth
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_start) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // RAM write port, registered one cycle after the pop; address/data hold when idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ram_we     <= 1'b0;
            r_ram_addr1  <= '0;
            r_ram_addr2  <= '0;
            r_ram_data1  <= '0;
            r_ram_data2  <= '0;
            r_stage_done <= 1'b0;
            r_fft_done   <= 1'b0;
        end else if (i_start) begin
            r_ram_we     <= 1'b0;
            r_stage_done <= 1'b0;
            r_fft_done   <= 1'b0;
        end else begin
            r_ram_we     <= w_pop;
            r_stage_done <= w_last_pair;
            r_fft_done   <= w_last_stage;
            if (w_pop) begin
                r_ram_addr1 <= r_fifo_addr1[r_rd_ptr];
                r_ram_addr2 <= r_fifo_addr2[r_rd_ptr];
                r_ram_data1 <= i_BPU_result1;
                r_ram_data2 <= i_BPU_result2;
            end
        end
    end

    // Pair and stage progress; the stage index returns to 0 after the final stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pair_count <= '0;
            r_stage      <= '0;
        end else if (i_start) begin
            r_pair_count <= '0;
            r_stage      <= '0;
        end else if (w_pop) begin
            if (w_last_pair) begin
                r_pair_count <= '0;
                r_stage      <= w_last_stage ? '0 : r_stage + 1'b1;
            end else begin
                r_pair_count <= r_pair_count + 1'b1;
            end
        end
    end

    // Sticky protocol error, cleared by a new transform
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else if (i_start) begin
            r_error <= 1'b0;
        end else if (w_err) begin
            r_error <= 1'b1;
        end
    end

    assign o_addr_ready      = w_ready;
    assign o_RAM_we          = r_ram_we;
    assign o_RAM_wr_address1 = r_ram_addr1;
    assign o_RAM_wr_address2 = r_ram_addr2;
    assign o_RAM_wr_data1    = r_ram_data1;
    assign o_RAM_wr_data2    = r_ram_data2;
    assign o_stage           = r_stage;
    assign o_stage_done      = r_stage_done;
    assign o_fft_done        = r_fft_done;
    assign o_error           = r_error;

endmodule

// File: tb/tb_fft_writeback_unit.sv
// Directed bench for fft_writeback_unit with N=8, 16-bit components, 8-entry FIFO.
module tb_fft_writeback_unit;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic        i_addr_valid;
    logic [2:0]  i_wr_address1;
    logic [2:0]  i_wr_address2;
    logic        o_addr_ready;
    logic        i_BPU_valid;
    logic [31:0] i_BPU_result1;
    logic [31:0] i_BPU_result2;
    logic        o_RAM_we;
    logic [2:0]  o_RAM_wr_address1;
    logic [2:0]  o_RAM_wr_address2;
    logic [31:0] o_RAM_wr_data1;
    logic [31:0] o_RAM_wr_data2;
    logic [1:0]  o_stage;
    logic        o_stage_done;
    logic        o_fft_done;
    logic        o_error;

    int n_checks;
    int n_fail;

    fft_writeback_unit #(
        .N         (8),
        .word_size (16),
        .fifo_depth(8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .i_start          (i_start),
        .i_addr_valid     (i_addr_valid),
        .i_wr_address1    (i_wr_address1),
        .i_wr_address2    (i_wr_address2),
        .o_addr_ready     (o_addr_ready),
        .i_BPU_valid      (i_BPU_valid),
        .i_BPU_result1    (i_BPU_result1),
        .i_BPU_result2    (i_BPU_result2),
        .o_RAM_we         (o_RAM_we),
        .o_RAM_wr_address1(o_RAM_wr_address1),
        .o_RAM_wr_address2(o_RAM_wr_address2),
        .o_RAM_wr_data1   (o_RAM_wr_data1),
        .o_RAM_wr_data2   (o_RAM_wr_data2),
        .o_stage          (o_stage),
        .o_stage_done     (o_stage_done),
        .o_fft_done       (o_fft_done),
        .o_error          (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // One pair: push, one gap cycle, BPU valid, then check the resulting write.
    task automatic do_pair(input int k, input int j);
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic [31:0] d1;
        logic [31:0] d2;
        a1 = k[2:0];
        a2 = ~a1;
        d1 = 32'h1000_0000 + 32'(k);
        d2 = 32'h2000_0000 + 32'(k);
        i_addr_valid  = 1'b1;
        i_wr_address1 = a1;
        i_wr_address2 = a2;
        tick();
        i_addr_valid = 1'b0;
        check_eq("we_idle_gap", {63'd0, o_RAM_we}, 64'd0);
        tick();
        i_BPU_valid   = 1'b1;
        i_BPU_result1 = d1;
        i_BPU_result2 = d2;
        tick();
        i_BPU_valid = 1'b0;
        check_eq("pair_we", {63'd0, o_RAM_we}, 64'd1);
        check_eq("pair_addr1", {61'd0, o_RAM_wr_address1}, {61'd0, a1});
        check_eq("pair_addr2", {61'd0, o_RAM_wr_address2}, {61'd0, a2});
        check_eq("pair_data1", {32'd0, o_RAM_wr_data1}, {32'd0, d1});
        check_eq("pair_data2", {32'd0, o_RAM_wr_data2}, {32'd0, d2});
        check_eq("pair_stage_done", {63'd0, o_stage_done}, {63'd0, (j % 4) == 3});
        check_eq("pair_fft_done", {63'd0, o_fft_done}, {63'd0, j == 11});
        check_eq("pair_stage", {62'd0, o_stage}, 64'(((j + 1) / 4) % 3));
        check_eq("pair_error", {63'd0, o_error}, 64'd0);
    endtask

    task automatic run_transform(input int base);
        for (int j = 0; j < 12; j++) begin
            do_pair(base + j, j);
        end
        check_eq("idle_after_done", {63'd0, o_addr_ready}, 64'd0);
    endtask

    task automatic push_pair(input logic [2:0] a1, input logic [2:0] a2);
        i_addr_valid  = 1'b1;
        i_wr_address1 = a1;
        i_wr_address2 = a2;
        tick();
        i_addr_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [2:0] a1, input logic [2:0] a2);
        i_BPU_valid = 1'b1;
        tick();
        i_BPU_valid = 1'b0;
        check_eq({tag, "_we"}, {63'd0, o_RAM_we}, 64'd1);
        check_eq({tag, "_a1"}, {61'd0, o_RAM_wr_address1}, {61'd0, a1});
        check_eq({tag, "_a2"}, {61'd0, o_RAM_wr_address2}, {61'd0, a2});
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        i_start       = 1'b0;
        i_addr_valid  = 1'b0;
        i_wr_address1 = '0;
        i_wr_address2 = '0;
        i_BPU_valid   = 1'b0;
        i_BPU_result1 = '0;
        i_BPU_result2 = '0;
        tick();
        tick();
        check_eq("rst_we", {63'd0, o_RAM_we}, 64'd0);
        check_eq("rst_ready", {63'd0, o_addr_ready}, 64'd0);
        check_eq("rst_stage", {62'd0, o_stage}, 64'd0);
        check_eq("rst_error", {63'd0, o_error}, 64'd0);
        reset = 1'b1;
        tick();

        // BPU valid while idle: no write, error raised, i_start clears it
        i_BPU_valid   = 1'b1;
        i_BPU_result1 = 32'hDEAD_BEEF;
        tick();
        i_BPU_valid = 1'b0;
        check_eq("idle_bpu_we", {63'd0, o_RAM_we}, 64'd0);
        check_eq("idle_bpu_err", {63'd0, o_error}, 64'd1);
        pulse_start();
        check_eq("start_clr_err", {63'd0, o_error}, 64'd0);
        check_eq("start_ready", {63'd0, o_addr_ready}, 64'd1);

        // Full N=8 transform: 12 writes, stage done at 4/8/12, fft done at 12
        run_transform(0);

        // Fill to full, overflow push rejected, contents intact
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            push_pair(3'(i), 3'(7 - i));
            check_eq("fill_ready", {63'd0, o_addr_ready}, {63'd0, i < 7});
        end
        push_pair(3'd5, 3'd5);
        check_eq("ovf_err", {63'd0, o_error}, 64'd1);
        check_eq("ovf_ready", {63'd0, o_addr_ready}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            pop_check("ovf_pop", 3'(i), 3'(7 - i));
        end

        // At full, simultaneous push and pop is legal and keeps order
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            push_pair(3'(i), 3'(7 - i));
        end
        i_addr_valid  = 1'b1;
        i_wr_address1 = 3'd7;
        i_wr_address2 = 3'd7;
        i_BPU_valid   = 1'b1;
        tick();
        i_addr_valid = 1'b0;
        i_BPU_valid  = 1'b0;
        check_eq("full_pp_we", {63'd0, o_RAM_we}, 64'd1);
        check_eq("full_pp_a1", {61'd0, o_RAM_wr_address1}, 64'd0);
        check_eq("full_pp_a2", {61'd0, o_RAM_wr_address2}, 64'd7);
        check_eq("full_pp_ready", {63'd0, o_addr_ready}, 64'd0);
        check_eq("full_pp_err", {63'd0, o_error}, 64'd0);
        for (int i = 1; i < 8; i++) begin
            pop_check("full_pop", 3'(i), 3'(7 - i));
        end
        pop_check("full_pop_last", 3'd7, 3'd7);
        check_eq("drained_ready", {63'd0, o_addr_ready}, 64'd1);

        // BPU valid with empty FIFO in RUN: no write, sticky error
        i_BPU_valid = 1'b1;
        tick();
        i_BPU_valid = 1'b0;
        check_eq("empty_bpu_we", {63'd0, o_RAM_we}, 64'd0);
        check_eq("empty_bpu_err", {63'd0, o_error}, 64'd1);
        tick();
        check_eq("err_sticky", {63'd0, o_error}, 64'd1);
        pulse_start();
        check_eq("err_cleared", {63'd0, o_error}, 64'd0);

        // Reset mid stage 1 with pairs in flight
        for (int j = 0; j < 4; j++) begin
            do_pair(20 + j, j);
        end
        push_pair(3'd1, 3'd2);
        push_pair(3'd3, 3'd4);
        push_pair(3'd5, 3'd6);
        pop_check("pre_rst_pop", 3'd1, 3'd2);
        check_eq("pre_rst_stage", {62'd0, o_stage}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check_eq("async_rst_we", {63'd0, o_RAM_we}, 64'd0);
        check_eq("async_rst_stage", {62'd0, o_stage}, 64'd0);
        check_eq("async_rst_a1", {61'd0, o_RAM_wr_address1}, 64'd0);
        check_eq("async_rst_d1", {32'd0, o_RAM_wr_data1}, 64'd0);
        check_eq("async_rst_ready", {63'd0, o_addr_ready}, 64'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_BPU_valid = 1'b1;
            tick();
            check_eq("post_rst_we", {63'd0, o_RAM_we}, 64'd0);
        end
        i_BPU_valid = 1'b0;
        pulse_start();
        run_transform(40);

        // Restart mid-RUN with pending pairs flushes everything
        pulse_start();
        push_pair(3'd2, 3'd3);
        push_pair(3'd4, 3'd5);
        push_pair(3'd6, 3'd7);
        pop_check("pre_restart_pop", 3'd2, 3'd3);
        i_start      = 1'b1;
        i_addr_valid = 1'b1;
        i_BPU_valid  = 1'b1;
        tick();
        i_start      = 1'b0;
        i_addr_valid = 1'b0;
        check_eq("restart_we", {63'd0, o_RAM_we}, 64'd0);
        check_eq("restart_stage", {62'd0, o_stage}, 64'd0);
        check_eq("restart_ready", {63'd0, o_addr_ready}, 64'd1);
        check_eq("restart_err", {63'd0, o_error}, 64'd0);
        tick();
        i_BPU_valid = 1'b0;
        check_eq("flushed_we", {63'd0, o_RAM_we}, 64'd0);
        check_eq("flushed_err", {63'd0, o_error}, 64'd1);
        pulse_start();
        run_transform(60);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
